// File: rtl/div_unit.sv
// Multi-cycle restoring radix-2 divider for RV32M DIV/DIVU/REM/REMU.
// Produces one quotient bit per cycle and returns registered results in END.
module div_unit #(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             annul_i,
  input  logic             signed_i,
  input  logic             rem_i,
  input  logic [WIDTH-1:0] opdata1_i,
  input  logic [WIDTH-1:0] opdata2_i,
  output logic [WIDTH-1:0] result_o,
  output logic             ready_o,
  output logic             busy_o
);

  localparam int CW = $clog2(ITER + 1);

  typedef enum logic [1:0] {
    S_FREE   = 2'd0,
    S_BYZERO = 2'd1,
    S_ON     = 2'd2,
    S_END    = 2'd3
  } state_t;

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
    return ~x + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic sgn);
    return (sgn && x[WIDTH-1]) ? negate(x) : x;
  endfunction

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;   // dividend shifts out as quotient shifts in
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic             qneg_q, qneg_d, rneg_q, rneg_d, remsel_q, remsel_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             ready_q, ready_d;

  logic [WIDTH+1:0] shift_s, diff_s;
  logic [WIDTH:0]   rem_next_s;
  logic [WIDTH-1:0] quo_next_s, q_final_s, r_final_s;

  assign shift_s    = {rem_q, quo_q[WIDTH-1]};
  assign diff_s     = shift_s - {2'b00, dvsr_q};
  assign rem_next_s = diff_s[WIDTH+1] ? shift_s[WIDTH:0] : diff_s[WIDTH:0];
  assign quo_next_s = {quo_q[WIDTH-2:0], ~diff_s[WIDTH+1]};
  assign q_final_s  = qneg_q ? negate(quo_next_s) : quo_next_s;
  assign r_final_s  = rneg_q ? negate(rem_next_s[WIDTH-1:0]) : rem_next_s[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_FREE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      remsel_q <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvsr_q   <= dvsr_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      remsel_q <= remsel_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FREE: begin
        if (start_i && !annul_i) begin
          state_d = (opdata2_i == '0) ? S_BYZERO : S_ON;
        end else begin
          state_d = S_FREE;
        end
      end
      S_BYZERO: state_d = annul_i ? S_FREE : S_END;
      S_ON: begin
        if (annul_i) begin
          state_d = S_FREE;
        end else if (cnt_q == CW'(ITER - 1)) begin
          state_d = S_END;
        end else begin
          state_d = S_ON;
        end
      end
      S_END:   state_d = start_i ? S_END : S_FREE;
      default: state_d = S_FREE;
    endcase
  end

  // Datapath and registered outputs; result is formed on the edge that enters END.
  always_comb begin
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvsr_d   = dvsr_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    remsel_d = remsel_q;
    result_d = result_q;
    ready_d  = ready_q;
    case (state_q)
      S_FREE: begin
        cnt_d = '0;
        if (start_i && !annul_i) begin
          remsel_d = rem_i;
          rem_d    = '0;
          if (opdata2_i == '0) begin
            quo_d  = opdata1_i;
            dvsr_d = '0;
            qneg_d = 1'b0;
            rneg_d = 1'b0;
          end else begin
            quo_d  = magnitude(opdata1_i, signed_i);
            dvsr_d = magnitude(opdata2_i, signed_i);
            qneg_d = signed_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
            rneg_d = signed_i & opdata1_i[WIDTH-1];
          end
        end else begin
          remsel_d = remsel_q;
        end
      end
      S_BYZERO: begin
        if (!annul_i) begin
          result_d = remsel_q ? quo_q : {WIDTH{1'b1}};
          ready_d  = 1'b1;
        end else begin
          ready_d = 1'b0;
        end
      end
      S_ON: begin
        if (!annul_i) begin
          rem_d = rem_next_s;
          quo_d = quo_next_s;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(ITER - 1)) begin
            result_d = remsel_q ? r_final_s : q_final_s;
            ready_d  = 1'b1;
          end else begin
            ready_d = 1'b0;
          end
        end else begin
          cnt_d = '0;
        end
      end
      S_END: begin
        if (!start_i) begin
          result_d = '0;
          ready_d  = 1'b0;
        end else begin
          ready_d = 1'b1;
        end
      end
      default: begin
        result_d = '0;
        ready_d  = 1'b0;
      end
    endcase
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;
  assign busy_o   = start_i & ~ready_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: latency, signed/unsigned results,
// divide-by-zero, overflow, annul, reset and result hold behaviour.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i, annul_i, signed_i, rem_i;
  logic [31:0] opdata1_i, opdata2_i;
  logic [31:0] result_o;
  logic        ready_o, busy_o;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  div_unit #(.WIDTH(32), .ITER(32)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .annul_i(annul_i),
    .signed_i(signed_i), .rem_i(rem_i), .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
    .result_o(result_o), .ready_o(ready_o), .busy_o(busy_o)
  );

  // Issue one op, scramble operands after capture, wait for ready, check, release.
  task automatic run_op(input string name, input logic sg, input logic rm,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_lat);
    int   n;
    logic busy_bad;
    @(negedge clk);
    signed_i = sg; rem_i = rm; opdata1_i = a; opdata2_i = b; start_i = 1'b1; annul_i = 1'b0;
    @(posedge clk); #1;
    n = 1;
    busy_bad = 1'b0;
    signed_i = ~sg; rem_i = ~rm; opdata1_i = 32'hDEAD_BEEF; opdata2_i = 32'h0000_0000;
    while (!ready_o && n < 40) begin
      if (busy_o !== 1'b1 || result_o !== 32'h0000_0000) busy_bad = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    tests_run++;
    if (ready_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s timeout: ready_o=%b required 1", name, ready_o);
    end
    tests_run++;
    if (n !== exp_lat) begin
      tests_failed++;
      $display("FAIL %s latency: got %0d edges required %0d", name, n, exp_lat);
    end
    tests_run++;
    if (result_o !== exp) begin
      tests_failed++;
      $display("FAIL %s result: got %h required %h", name, result_o, exp);
    end
    tests_run++;
    if (busy_bad !== 1'b0 || busy_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s busy/idle-result: bad=%b busy_o=%b required 0,0", name, busy_bad, busy_o);
    end
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if (ready_o !== 1'b0 || result_o !== 32'h0000_0000) begin
      tests_failed++;
      $display("FAIL %s release: ready=%b result=%h required 0,0", name, ready_o, result_o);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_i = 1'b0; rem_i = 1'b0;
    opdata1_i = 32'h0; opdata2_i = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (ready_o !== 1'b0 || result_o !== 32'h0 || busy_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset: ready=%b result=%h busy=%b required 0,0,0", ready_o, result_o, busy_o);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_unsigned();
    run_op("divu_100_7", 1'b0, 1'b0, 32'd100, 32'd7, 32'd14, 33);
    run_op("remu_100_7", 1'b0, 1'b1, 32'd100, 32'd7, 32'd2, 33);
  endtask

  task automatic test_signed();
    run_op("div_m7_2",  1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    run_op("rem_m7_2",  1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    run_op("rem_7_m2",  1'b1, 1'b1, 32'd7, 32'hFFFF_FFFE, 32'd1, 33);
    run_op("div_7_m2",  1'b1, 1'b0, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
  endtask

  task automatic test_overflow();
    run_op("div_ovf", 1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33);
    run_op("rem_ovf", 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 33);
  endtask

  task automatic test_divzero();
    run_op("divu_5_0", 1'b0, 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 2);
    run_op("remu_5_0", 1'b0, 1'b1, 32'd5, 32'd0, 32'd5, 2);
    run_op("div_m5_0", 1'b1, 1'b0, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 2);
    run_op("rem_m5_0", 1'b1, 1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 2);
  endtask

  task automatic test_annul();
    logic rose;
    @(negedge clk);
    signed_i = 1'b0; rem_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
    rose = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (ready_o) rose = 1'b1;
    end
    @(negedge clk);
    annul_i = 1'b1; start_i = 1'b0;
    @(posedge clk); #1;
    if (ready_o) rose = 1'b1;
    annul_i = 1'b0;
    tests_run++;
    if (rose !== 1'b0 || result_o !== 32'h0) begin
      tests_failed++;
      $display("FAIL annul_no_result: rose=%b result=%h required 0,0", rose, result_o);
    end
    // Issued immediately: full latency proves the unit is back in FREE.
    run_op("divu_9_3_after_annul", 1'b0, 1'b0, 32'd9, 32'd3, 32'd3, 33);
  endtask

  task automatic test_annul_with_start();
    logic rose;
    @(negedge clk);
    signed_i = 1'b0; rem_i = 1'b0; opdata1_i = 32'd50; opdata2_i = 32'd5;
    start_i = 1'b1; annul_i = 1'b1;
    rose = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (ready_o) rose = 1'b1;
    end
    tests_run++;
    if (rose !== 1'b0 || busy_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL annul_and_start: rose=%b busy=%b required 0,1", rose, busy_o);
    end
    @(negedge clk);
    annul_i = 1'b0; start_i = 1'b0;
    @(posedge clk);
    run_op("divu_50_5", 1'b0, 1'b0, 32'd50, 32'd5, 32'd10, 33);
  endtask

  task automatic test_hold();
    int   n;
    logic unstable;
    @(negedge clk);
    signed_i = 1'b0; rem_i = 1'b0; opdata1_i = 32'd77; opdata2_i = 32'd11; start_i = 1'b1;
    n = 0;
    while (!ready_o && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    unstable = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (ready_o !== 1'b1 || result_o !== 32'd7) unstable = 1'b1;
    end
    tests_run++;
    if (unstable !== 1'b0 || n !== 33) begin
      tests_failed++;
      $display("FAIL hold: unstable=%b latency=%0d result=%h required 0,33,00000007", unstable, n, result_o);
    end
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if (ready_o !== 1'b0 || result_o !== 32'h0) begin
      tests_failed++;
      $display("FAIL hold_release: ready=%b result=%h required 0,0", ready_o, result_o);
    end
  endtask

  task automatic test_rst_mid();
    logic rose;
    @(negedge clk);
    signed_i = 1'b0; rem_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1; start_i = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if (ready_o !== 1'b0 || result_o !== 32'h0) begin
      tests_failed++;
      $display("FAIL rst_mid: ready=%b result=%h required 0,0", ready_o, result_o);
    end
    @(negedge clk);
    rst = 1'b0;
    rose = 1'b0;
    repeat (36) begin
      @(posedge clk); #1;
      if (ready_o) rose = 1'b1;
    end
    tests_run++;
    if (rose !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_mid_no_result: rose=%b required 0", rose);
    end
    run_op("divu_after_rst", 1'b0, 1'b0, 32'd1000, 32'd3, 32'd333, 33);
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_overflow();
    test_divzero();
    test_annul();
    test_annul_with_start();
    test_hold();
    test_rst_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
